// File: rtl/ui_pkg.sv
// ---------------------------------------------------------------------------
// ui_pkg
// Shared definitions for the user-interface input blocks.
//   db_state_e  : debounce FSM states (UP, PRESS_CHK, DOWN, RELEASE_CHK)
//   clamp_min1  : clamps an integer to at least 1 (used for clock dividers)
//   max_int     : larger of two integers (used for counter sizing)
// ---------------------------------------------------------------------------
package ui_pkg;

   typedef enum logic [1:0] {
      ST_UP          = 2'd0,
      ST_PRESS_CHK   = 2'd1,
      ST_DOWN        = 2'd2,
      ST_RELEASE_CHK = 2'd3
   } db_state_e;

   function automatic int clamp_min1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sample_tick.sv
// ---------------------------------------------------------------------------
// sample_tick
// Free-running divider: tick is high for one clk out of every DIV clks.
// The counter restarts from zero on reset, so the first tick follows
// DIV clks after rst falls.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : one-clk strobe every DIV cycles (constantly high when DIV == 1)
// ---------------------------------------------------------------------------
module sample_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // One spare bit so the terminal value DIV-1 always fits without wrapping.
   localparam int CW = $clog2(DIV) + 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Push-button conditioner: 2-flop synchronizer, sampled debounce FSM and
// one-clk press / release strobes. A level change is accepted only after
// STABLE_SAMPLES consecutive equal samples taken at SAMPLE_HZ.
//
// Optional feature (macro BUTTON_AUTOREPEAT_EN): while the button stays
// down, an extra press strobe is issued after REPEAT_DELAY samples and then
// every REPEAT_RATE samples.
//
// Ports
//   clk           : system clock (CLK_HZ)
//   rst           : asynchronous active-high reset
//   btn_in        : raw push-button, active-high, asynchronous to clk
//   level         : debounced button state (1 = pressed)
//   press         : one-clk strobe per accepted press (and per auto-repeat)
//   release_pulse : one-clk strobe per accepted release ("release" on its own
//                   is a reserved word in SystemVerilog)
// ---------------------------------------------------------------------------
module button_debounce
   import ui_pkg::*;
#(
   parameter int CLK_HZ         = 100000000,
   parameter int SAMPLE_HZ      = 1000,
   parameter int STABLE_SAMPLES = 8,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int DIV = clamp_min1(CLK_HZ / SAMPLE_HZ);
   localparam int SCW = $clog2(STABLE_SAMPLES) + 1;

   logic [1:0]     sync_q, sync_d;
   logic           sample;
   logic           tick;
   db_state_e      state_q, state_d;
   logic [SCW-1:0] stable_cnt_q, stable_cnt_d;
   logic           press_q, press_d;
   logic           release_q, release_d;
   logic           fsm_press;
   logic           rep_fire;

   assign sync_d = {sync_q[0], btn_in};
   assign sample = sync_q[1];

   sample_tick #(
      .DIV (DIV)
   ) u_sample_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Debounce FSM: only advances on a sample tick, holds otherwise.
   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      if (tick) begin
         case (state_q)
            ST_UP: begin
               if (sample) begin
                  state_d      = ST_PRESS_CHK;
                  stable_cnt_d = SCW'(1);
               end
            end
            ST_PRESS_CHK: begin
               if (!sample) begin
                  state_d = ST_UP;
               end else begin
                  stable_cnt_d = stable_cnt_q + SCW'(1);
                  if (stable_cnt_q + SCW'(1) >= SCW'(STABLE_SAMPLES)) begin
                     state_d = ST_DOWN;
                  end
               end
            end
            ST_DOWN: begin
               if (!sample) begin
                  state_d      = ST_RELEASE_CHK;
                  stable_cnt_d = SCW'(1);
               end
            end
            ST_RELEASE_CHK: begin
               if (sample) begin
                  state_d = ST_DOWN;
               end else begin
                  stable_cnt_d = stable_cnt_q + SCW'(1);
                  if (stable_cnt_q + SCW'(1) >= SCW'(STABLE_SAMPLES)) begin
                     state_d = ST_UP;
                  end
               end
            end
            default: begin
               state_d = ST_UP;
            end
         endcase
      end
   end

   assign fsm_press = (state_q == ST_PRESS_CHK) && (state_d == ST_DOWN);
   assign release_d = (state_q == ST_RELEASE_CHK) && (state_d == ST_UP);
   assign press_d   = fsm_press | rep_fire;

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_RATE);
   localparam int RW   = $clog2(RMAX) + 1;

   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_armed_q, rep_armed_d;  // 0: waiting out the first delay
   logic [RW-1:0] rep_target;
   logic          rep_fire_c;

   assign rep_target = rep_armed_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

   // Only a fresh press restarts the repeat timer. A bounce that drops
   // into RELEASE_CHK and comes back to DOWN resumes the count where it
   // stopped, because the counter advances only on ticks that stay in DOWN.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      rep_fire_c  = 1'b0;
      if (fsm_press) begin
         rep_cnt_d   = '0;
         rep_armed_d = 1'b0;
      end else if ((state_q == ST_DOWN) && tick && sample) begin
         if (rep_cnt_q + RW'(1) >= rep_target) begin
            rep_fire_c  = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
         end
      end
   end

   assign rep_fire = rep_fire_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q       <= '0;
         state_q      <= ST_UP;
         stable_cnt_q <= '0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
         press_q      <= press_d;
         release_q    <= release_d;
      end
   end

   assign level         = (state_q == ST_DOWN) || (state_q == ST_RELEASE_CHK);
   assign press         = press_q;
   assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
// Scoreboarded bench for button_debounce (DIV = 10, 4 stable samples,
// repeat after 6 samples then every 3). Each test pushes the pulses it
// expects (kind + cycle window, absolute or relative to the previous pulse)
// and then compares them against the pulses the monitor recorded.
// Build with BUTTON_AUTOREPEAT_EN to also expect the auto-repeat strobes.
// ---------------------------------------------------------------------------
module tb_button_debounce;

   localparam int CLK_HZ    = 1000;
   localparam int SAMPLE_HZ = 100;
   localparam int STABLE    = 4;
   localparam int RDELAY    = 6;
   localparam int RRATE     = 3;
   localparam int DIV       = 10;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic level;
   logic press;
   logic release_pulse;

   always #5 clk = ~clk;

   button_debounce #(
      .CLK_HZ         (CLK_HZ),
      .SAMPLE_HZ      (SAMPLE_HZ),
      .STABLE_SAMPLES (STABLE),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_RATE    (RRATE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .level         (level),
      .press         (press),
      .release_pulse (release_pulse)
   );

   typedef struct {
      bit is_press;
      bit rel;       // window relative to the previous observed pulse
      int lo;
      int hi;
   } exp_t;

   typedef struct {
      bit p;
      bit r;
      int cyc;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_mem[128];
   int   obs_wr = 0;
   int   obs_rd = 0;
   int   cyc = 0;
   int   tick_ph = 0;
   int   last_cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   // Cycle counter and sample-tick phase (tick is due when tick_ph == DIV-1).
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) tick_ph <= 0;
      else     tick_ph <= (tick_ph == DIV - 1) ? 0 : tick_ph + 1;
   end

   // Pulse monitor: records every press/release strobe with its cycle.
   always @(negedge clk) begin
      if ((press || release_pulse) && obs_wr < 128) begin
         obs_mem[obs_wr] <= '{press, release_pulse, cyc};
         obs_wr <= obs_wr + 1;
      end
   end

   // Puts the next btn_in edge 4 cycles after a sample tick.
   task automatic align_to_tick;
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (tick_ph != DIV - 1 && guard < 20);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      btn_in = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (level !== 1'b0 || press !== 1'b0 || release_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL reset outputs got level=%0b press=%0b release=%0b, want 0 0 0",
                  level, press, release_pulse);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (level !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle level got %0b, want 0", level);
      end
      $display("test_reset done");
   endtask

   task automatic test_clean_press;
      int   c0;
      obs_t o;
      exp_t e;
      int   lo, hi;
      align_to_tick();
      btn_in = 1'b1;
      c0 = cyc;
      exp_q.push_back('{1'b1, 1'b0, c0 + 32, c0 + 52});
`ifdef BUTTON_AUTOREPEAT_EN
      exp_q.push_back('{1'b1, 1'b1, 60, 60});
      exp_q.push_back('{1'b1, 1'b1, 30, 30});
`endif
      repeat (60) @(negedge clk);
      while (obs_rd < obs_wr) begin
         o = obs_mem[obs_rd];
         obs_rd++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL clean_press pulse p=%0b r=%0b at cyc %0d, want none", o.p, o.r, o.cyc);
         end else begin
            e = exp_q.pop_front();
            lo = e.rel ? last_cyc + e.lo : e.lo;
            hi = e.rel ? last_cyc + e.hi : e.hi;
            if (o.p !== e.is_press || o.r !== !e.is_press || o.cyc < lo || o.cyc > hi) begin
               miscompares++;
               $display("FAIL clean_press pulse got p=%0b r=%0b cyc=%0d, want p=%0b cyc in [%0d,%0d]",
                        o.p, o.r, o.cyc, e.is_press, lo, hi);
            end else begin
               $display("clean_press: pulse p=%0b at cyc %0d", o.p, o.cyc);
            end
         end
         last_cyc = o.cyc;
      end
      vectors++;
`ifdef BUTTON_AUTOREPEAT_EN
      if (exp_q.size() !== 2) begin
`else
      if (exp_q.size() !== 0) begin
`endif
         miscompares++;
         $display("FAIL clean_press pending expectations got %0d after 60 clk", exp_q.size());
      end
      repeat (40) @(negedge clk);
      vectors++;
      if (level !== 1'b1) begin
         miscompares++;
         $display("FAIL clean_press level got %0b, want 1", level);
      end
   endtask

   task automatic test_clean_release;
      int   c1;
      obs_t o;
      exp_t e;
      int   lo, hi;
      repeat (50) @(negedge clk);   // button held 150 clk in total
      btn_in = 1'b0;
      c1 = cyc;
      exp_q.push_back('{1'b0, 1'b0, c1 + 1, c1 + 52});
      repeat (60) @(negedge clk);
      while (obs_rd < obs_wr) begin
         o = obs_mem[obs_rd];
         obs_rd++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL clean_release pulse p=%0b r=%0b at cyc %0d, want none", o.p, o.r, o.cyc);
         end else begin
            e = exp_q.pop_front();
            lo = e.rel ? last_cyc + e.lo : e.lo;
            hi = e.rel ? last_cyc + e.hi : e.hi;
            if (o.p !== e.is_press || o.r !== !e.is_press || o.cyc < lo || o.cyc > hi) begin
               miscompares++;
               $display("FAIL clean_release pulse got p=%0b r=%0b cyc=%0d, want p=%0b cyc in [%0d,%0d]",
                        o.p, o.r, o.cyc, e.is_press, lo, hi);
            end else begin
               $display("clean_release: pulse p=%0b at cyc %0d", o.p, o.cyc);
            end
         end
         last_cyc = o.cyc;
      end
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL clean_release missing pulses got %0d pending, want 0", exp_q.size());
         exp_q.delete();
      end
      vectors++;
      if (level !== 1'b0) begin
         miscompares++;
         $display("FAIL clean_release level got %0b, want 0", level);
      end
   endtask

   task automatic test_bounce;
      int start_wr;
      start_wr = obs_wr;
      for (int t = 0; t < 200; t++) begin
         btn_in = ((t / 15) % 2 == 0) ? 1'b1 : 1'b0;
         @(negedge clk);
         vectors++;
         if (level !== 1'b0 || press !== 1'b0 || release_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce t=%0d got level=%0b press=%0b release=%0b, want 0 0 0",
                     t, level, press, release_pulse);
         end
      end
      btn_in = 1'b0;
      repeat (60) @(negedge clk);
      vectors++;
      if (obs_wr !== start_wr || level !== 1'b0) begin
         miscompares++;
         $display("FAIL bounce_settle got %0d pulses level=%0b, want 0 pulses level=0",
                  obs_wr - start_wr, level);
      end
      obs_rd = obs_wr;
      $display("test_bounce done");
   endtask

   task automatic test_reset_mid_check;
      int   cr, c1;
      obs_t o;
      exp_t e;
      int   lo, hi;
      @(negedge clk);
      btn_in = 1'b1;
      repeat (20) @(negedge clk);   // sampled high, not yet accepted
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (level !== 1'b0 || press !== 1'b0 || release_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid outputs got level=%0b press=%0b release=%0b, want 0 0 0",
                  level, press, release_pulse);
      end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      cr = cyc;
      exp_q.push_back('{1'b1, 1'b0, cr + 32, cr + 52});
      repeat (20) @(negedge clk);
      vectors++;
      if (level !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_requal early level got %0b, want 0", level);
      end
      repeat (35) @(negedge clk);
      vectors++;
      if (level !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_requal level got %0b, want 1", level);
      end
      btn_in = 1'b0;
      c1 = cyc;
      exp_q.push_back('{1'b0, 1'b0, c1 + 1, c1 + 52});
      repeat (60) @(negedge clk);
      while (obs_rd < obs_wr) begin
         o = obs_mem[obs_rd];
         obs_rd++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL reset_mid pulse p=%0b r=%0b at cyc %0d, want none", o.p, o.r, o.cyc);
         end else begin
            e = exp_q.pop_front();
            lo = e.rel ? last_cyc + e.lo : e.lo;
            hi = e.rel ? last_cyc + e.hi : e.hi;
            if (o.p !== e.is_press || o.r !== !e.is_press || o.cyc < lo || o.cyc > hi) begin
               miscompares++;
               $display("FAIL reset_mid pulse got p=%0b r=%0b cyc=%0d, want p=%0b cyc in [%0d,%0d]",
                        o.p, o.r, o.cyc, e.is_press, lo, hi);
            end else begin
               $display("reset_mid: pulse p=%0b at cyc %0d", o.p, o.cyc);
            end
         end
         last_cyc = o.cyc;
      end
      vectors++;
      if (exp_q.size() !== 0 || level !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid end got %0d pending level=%0b, want 0 pending level=0",
                  exp_q.size(), level);
         exp_q.delete();
      end
   endtask

   task automatic test_autorepeat;
      int   c0, c1;
      obs_t o;
      exp_t e;
      int   lo, hi;
      align_to_tick();
      btn_in = 1'b1;
      c0 = cyc;
      exp_q.push_back('{1'b1, 1'b0, c0 + 32, c0 + 52});
`ifdef BUTTON_AUTOREPEAT_EN
      exp_q.push_back('{1'b1, 1'b1, 60, 60});
      for (int k = 0; k < 3; k++) exp_q.push_back('{1'b1, 1'b1, 30, 30});
`endif
      repeat (200) @(negedge clk);
      btn_in = 1'b0;
      c1 = cyc;
      exp_q.push_back('{1'b0, 1'b0, c1 + 1, c1 + 52});
      repeat (60) @(negedge clk);
      while (obs_rd < obs_wr) begin
         o = obs_mem[obs_rd];
         obs_rd++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL autorepeat pulse p=%0b r=%0b at cyc %0d, want none", o.p, o.r, o.cyc);
         end else begin
            e = exp_q.pop_front();
            lo = e.rel ? last_cyc + e.lo : e.lo;
            hi = e.rel ? last_cyc + e.hi : e.hi;
            if (o.p !== e.is_press || o.r !== !e.is_press || o.cyc < lo || o.cyc > hi) begin
               miscompares++;
               $display("FAIL autorepeat pulse got p=%0b r=%0b cyc=%0d, want p=%0b cyc in [%0d,%0d]",
                        o.p, o.r, o.cyc, e.is_press, lo, hi);
            end else begin
               $display("autorepeat: pulse p=%0b at cyc %0d", o.p, o.cyc);
            end
         end
         last_cyc = o.cyc;
      end
      vectors++;
      if (exp_q.size() !== 0 || level !== 1'b0) begin
         miscompares++;
         $display("FAIL autorepeat end got %0d pending level=%0b, want 0 pending level=0",
                  exp_q.size(), level);
         exp_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      btn_in = 1'b0;
      test_reset();
      test_clean_press();
      test_clean_release();
      test_bounce();
      test_reset_mid_check();
      test_autorepeat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
